// File: rtl/trap_ctrl_pkg.sv
// Shared trap definitions: cause codes, CSR addresses, sequencer states and
// the priority-encoder result record. TRAP_MTVAL_EN adds the mtval write state.
package trap_ctrl_pkg;

  localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_IACCESS   = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_BREAK     = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M   = 4'd11;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_WR_EPC   = 3'd2,
    ST_WR_CAUSE = 3'd3,
`ifdef TRAP_MTVAL_EN
    ST_WR_TVAL  = 3'd4,
`endif
    ST_REDIRECT = 3'd5
  } state_e;

  typedef struct packed {
    logic       trap;
    logic       is_mret;
    logic [3:0] cause;
  } trap_sel_t;

endpackage

// File: rtl/trap_prio_enc.sv
// Picks the highest-priority writeback trap; any exception masks mret.
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic      misalign_i,
  input  logic      bus_err_i,
  input  logic      ilegl_i,
  input  logic      ebreak_i,
  input  logic      ecall_i,
  input  logic      mret_i,
  output trap_sel_t sel_o
);

  always_comb begin
    sel_o      = '0;
    sel_o.trap = misalign_i | bus_err_i | ilegl_i | ebreak_i | ecall_i | mret_i;
    if (misalign_i)     sel_o.cause = CAUSE_IMISALIGN;
    else if (bus_err_i) sel_o.cause = CAUSE_IACCESS;
    else if (ilegl_i)   sel_o.cause = CAUSE_ILLEGAL;
    else if (ebreak_i)  sel_o.cause = CAUSE_BREAK;
    else if (ecall_i)   sel_o.cause = CAUSE_ECALL_M;
    else if (mret_i)    sel_o.is_mret = 1'b1;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Writeback trap sequencer: kill, flush, mepc/mcause(/mtval) CSR writes, redirect.
// Optional TRAP_MTVAL_EN inserts an mtval write after mcause.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int XLEN_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid_i,
  input  logic [PC_W-1:0]   wb_pc_i,
  input  logic              wb_excp_misalign_i,
  input  logic              wb_excp_bus_err_i,
  input  logic              wb_excp_ilegl_instr_i,
  input  logic              wb_excp_ebreak_i,
  input  logic              wb_excp_ecall_i,
  input  logic              wb_excp_mret_i,
  input  logic [XLEN_W-1:0] mtvec_i,
  input  logic [XLEN_W-1:0] mepc_i,
  output logic              csr_wr_valid_o,
  output logic [11:0]       csr_wr_addr_o,
  output logic [XLEN_W-1:0] csr_wr_data_o,
  input  logic              csr_wr_ready_i,
  output logic              wb_kill_o,
  output logic              flush_o,
  output logic              busy_o,
  output logic              redirect_valid_o,
  output logic [PC_W-1:0]   redirect_pc_o,
  output logic [CNT_W-1:0]  trap_cnt_o
);

  state_e            state_q, state_d;
  logic [3:0]        fcnt_q, fcnt_d;
  logic [3:0]        cause_q, cause_d;
  logic              mret_q, mret_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN_W-1:0] pc_ext;
  trap_sel_t         sel;
  logic              trap;

  trap_prio_enc u_prio (
    .misalign_i (wb_excp_misalign_i),
    .bus_err_i  (wb_excp_bus_err_i),
    .ilegl_i    (wb_excp_ilegl_instr_i),
    .ebreak_i   (wb_excp_ebreak_i),
    .ecall_i    (wb_excp_ecall_i),
    .mret_i     (wb_excp_mret_i),
    .sel_o      (sel)
  );

  assign trap       = wb_valid_i & sel.trap;
  assign busy_o     = (state_q != ST_IDLE);
  assign trap_cnt_o = cnt_q;

  always_comb begin
    pc_ext             = '0;
    pc_ext[PC_W-1:0]   = pc_q;
  end

  always_comb begin
    state_d          = state_q;
    fcnt_d           = fcnt_q;
    cause_d          = cause_q;
    mret_d           = mret_q;
    pc_d             = pc_q;
    tgt_d            = tgt_q;
    cnt_d            = cnt_q;
    wb_kill_o        = 1'b0;
    flush_o          = 1'b0;
    csr_wr_valid_o   = 1'b0;
    csr_wr_addr_o    = '0;
    csr_wr_data_o    = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    case (state_q)
      ST_IDLE: if (trap) begin
        wb_kill_o = 1'b1;
        state_d   = ST_FLUSH;
        fcnt_d    = 4'(FLUSH_CYCLES - 1);
        cause_d   = sel.cause;
        mret_d    = sel.is_mret;
        pc_d      = wb_pc_i;
        tgt_d     = sel.is_mret ? mepc_i[PC_W-1:0] : {mtvec_i[PC_W-1:2], 2'b00};
        if (!sel.is_mret) cnt_d = cnt_q + CNT_W'(1);
      end
      ST_FLUSH: begin
        flush_o = 1'b1;
        if (fcnt_q == 4'd0) state_d = mret_q ? ST_REDIRECT : ST_WR_EPC;
        else                fcnt_d  = fcnt_q - 4'd1;
      end
      // CSR data comes only from latched registers, so it holds while stalled.
      ST_WR_EPC: begin
        csr_wr_valid_o = 1'b1;
        csr_wr_addr_o  = CSR_MEPC;
        csr_wr_data_o  = pc_ext;
        if (csr_wr_ready_i) state_d = ST_WR_CAUSE;
      end
      ST_WR_CAUSE: begin
        csr_wr_valid_o     = 1'b1;
        csr_wr_addr_o      = CSR_MCAUSE;
        csr_wr_data_o[3:0] = cause_q;
`ifdef TRAP_MTVAL_EN
        if (csr_wr_ready_i) state_d = ST_WR_TVAL;
`else
        if (csr_wr_ready_i) state_d = ST_REDIRECT;
`endif
      end
`ifdef TRAP_MTVAL_EN
      ST_WR_TVAL: begin
        csr_wr_valid_o = 1'b1;
        csr_wr_addr_o  = CSR_MTVAL;
        csr_wr_data_o  = (cause_q <= CAUSE_IACCESS) ? pc_ext : '0;
        if (csr_wr_ready_i) state_d = ST_REDIRECT;
      end
`endif
      ST_REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = tgt_q;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
      pc_q    <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: transaction-queue model plus directed literals.
module tb_trap_ctrl;
  localparam int PC_W = 32, XLEN_W = 32, FC = 2, CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n, wb_valid, mis, bus, il, eb, ec, mr, ready;
  logic [PC_W-1:0]   pc;
  logic [XLEN_W-1:0] mtvec, mepc;
  logic              csr_wr_valid_o, wb_kill_o, flush_o, busy_o, redirect_valid_o;
  logic [11:0]       csr_wr_addr_o;
  logic [XLEN_W-1:0] csr_wr_data_o;
  logic [PC_W-1:0]   redirect_pc_o;
  logic [CNT_W-1:0]  trap_cnt_o;

  always #5 clk = ~clk;

  trap_ctrl #(.PC_W(PC_W), .XLEN_W(XLEN_W), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid_i(wb_valid), .wb_pc_i(pc),
    .wb_excp_misalign_i(mis), .wb_excp_bus_err_i(bus), .wb_excp_ilegl_instr_i(il),
    .wb_excp_ebreak_i(eb), .wb_excp_ecall_i(ec), .wb_excp_mret_i(mr),
    .mtvec_i(mtvec), .mepc_i(mepc),
    .csr_wr_valid_o(csr_wr_valid_o), .csr_wr_addr_o(csr_wr_addr_o),
    .csr_wr_data_o(csr_wr_data_o), .csr_wr_ready_i(ready),
    .wb_kill_o(wb_kill_o), .flush_o(flush_o), .busy_o(busy_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .trap_cnt_o(trap_cnt_o)
  );

  // Model: each trap becomes a list of per-cycle steps; writes stay at the
  // head until the CSR port accepts them.
  typedef struct { int kind; logic [11:0] addr; logic [31:0] data; } step_t;
  localparam int K_FLUSH = 0, K_WR = 1, K_RED = 2;
  step_t       q[$];
  logic [31:0] m_cnt = '0;
  int          n_pass = 0, n_tot = 0;
  bit          chk_en = 1'b0;

  function automatic step_t mk(int k, logic [11:0] a, logic [31:0] d);
    step_t s;
    s.kind = k; s.addr = a; s.data = d;
    return s;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
  endfunction

  always @(negedge clk) begin : cmp
    bit          any, e_fl, e_wv, e_rv;
    logic [11:0] e_ad;
    logic [31:0] e_wd, e_rp, cause;
    if (chk_en) begin
      any  = wb_valid & (mis | bus | il | eb | ec | mr);
      e_fl = 0; e_wv = 0; e_rv = 0; e_ad = '0; e_wd = '0; e_rp = '0;
      if (q.size() > 0) begin
        case (q[0].kind)
          K_FLUSH: e_fl = 1;
          K_WR:    begin e_wv = 1; e_ad = q[0].addr; e_wd = q[0].data; end
          default: begin e_rv = 1; e_rp = q[0].data; end
        endcase
      end
      chk("kill",   wb_kill_o,        64'(q.size() == 0 && any));
      chk("flush",  flush_o,          64'(e_fl));
      chk("busy",   busy_o,           64'(q.size() != 0));
      chk("wvalid", csr_wr_valid_o,   64'(e_wv));
      chk("waddr",  csr_wr_addr_o,    64'(e_ad));
      chk("wdata",  csr_wr_data_o,    64'(e_wd));
      chk("rvalid", redirect_valid_o, 64'(e_rv));
      chk("rpc",    redirect_pc_o,    64'(e_rp));
      chk("cnt",    trap_cnt_o,       64'(m_cnt));
      if (!rst_n) begin
        q.delete(); m_cnt = '0;
      end else if (q.size() == 0) begin
        if (any) begin
          for (int i = 0; i < FC; i++) q.push_back(mk(K_FLUSH, 0, 0));
          if (mis | bus | il | eb | ec) begin
            cause = mis ? 0 : bus ? 1 : il ? 2 : eb ? 3 : 11;
            q.push_back(mk(K_WR, 12'h341, pc));
            q.push_back(mk(K_WR, 12'h342, cause));
`ifdef TRAP_MTVAL_EN
            q.push_back(mk(K_WR, 12'h343, (cause < 2) ? pc : 32'h0));
`endif
            q.push_back(mk(K_RED, 0, mtvec & 32'hFFFF_FFFC));
            m_cnt = m_cnt + 1;
          end else begin
            q.push_back(mk(K_RED, 0, mepc));
          end
        end
      end else if (!(q[0].kind == K_WR && !ready)) begin
        void'(q.pop_front());
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic neg();  @(negedge clk);     endtask
  task automatic clr();
    wb_valid = 0; mis = 0; bus = 0; il = 0; eb = 0; ec = 0; mr = 0;
  endtask

  initial begin
    rst_n = 0; clr(); ready = 1; pc = '0; mtvec = '0; mepc = '0;
    tick(); chk_en = 1;
    neg();
    chk("rst_busy", busy_o, 0); chk("rst_cnt", trap_cnt_o, 0);
    tick(); rst_n = 1;

    // illegal instruction, ready always high
    tick(); wb_valid = 1; il = 1; pc = 32'h8000_0010; mtvec = 32'h8000_0101; mepc = 32'h8000_0200;
    neg(); chk("t1_kill", wb_kill_o, 1);
    tick(); clr(); neg(); chk("t1_flush", flush_o, 1);
    tick(); tick(); neg();
    chk("t1_epc_a", csr_wr_addr_o, 12'h341); chk("t1_epc_d", csr_wr_data_o, 32'h8000_0010);
    tick(); neg();
    chk("t1_cause_a", csr_wr_addr_o, 12'h342); chk("t1_cause_d", csr_wr_data_o, 2);
    tick(); neg();
`ifdef TRAP_MTVAL_EN
    chk("t1_tval_d", csr_wr_data_o, 0);
    tick(); neg();
`endif
    chk("t1_rv", redirect_valid_o, 1); chk("t1_rpc", redirect_pc_o, 32'h8000_0100);
    chk("t1_cnt", trap_cnt_o, 1);

    // misalign + ecall + mret together: cause 0, redirect to mtvec
    tick(); wb_valid = 1; mis = 1; ec = 1; mr = 1; pc = 32'h8000_0020; mtvec = 32'h8000_0400;
    tick(); clr(); tick(); tick(); neg();
    chk("t2_epc_d", csr_wr_data_o, 32'h8000_0020);
    tick(); neg(); chk("t2_cause_d", csr_wr_data_o, 0);
    tick(); neg();
`ifdef TRAP_MTVAL_EN
    chk("t2_tval_a", csr_wr_addr_o, 12'h343); chk("t2_tval_d", csr_wr_data_o, 32'h8000_0020);
    tick(); neg();
`endif
    chk("t2_rpc", redirect_pc_o, 32'h8000_0400);

    // mret alone: no CSR writes, redirect to mepc at T+3
    tick(); wb_valid = 1; mr = 1; mepc = 32'h8000_0200;
    tick(); clr(); tick(); neg(); chk("t3_nowr", csr_wr_valid_o, 0);
    tick(); neg();
    chk("t3_rv", redirect_valid_o, 1); chk("t3_rpc", redirect_pc_o, 32'h8000_0200);
    chk("t3_cnt", trap_cnt_o, 2);

    // ecall with CSR port stalled 4 cycles in WR_EPC
    tick(); wb_valid = 1; ec = 1; pc = 32'h8000_0044; ready = 0;
    tick(); clr(); tick(); tick(); neg();
    chk("t4_hold0", csr_wr_addr_o, 12'h341);
    tick(); tick(); tick(); neg();
    chk("t4_hold3_v", csr_wr_valid_o, 1); chk("t4_hold3_d", csr_wr_data_o, 32'h8000_0044);
    tick(); ready = 1; tick(); neg();
    chk("t4_cause_d", csr_wr_data_o, 11);
    tick(); neg();
`ifdef TRAP_MTVAL_EN
    tick(); neg();
`endif
    chk("t4_rv", redirect_valid_o, 1); chk("t4_cnt", trap_cnt_o, 3);

    // ebreak, reset asserted while in WR_CAUSE; invalid flags afterwards
    tick(); wb_valid = 1; eb = 1; pc = 32'h8000_0080;
    tick(); clr(); tick(); tick(); tick();
    rst_n = 0; mis = 1; bus = 1; il = 1; eb = 1; ec = 1; mr = 1;
    neg(); chk("t5_cause_a", csr_wr_addr_o, 12'h342);
    tick(); rst_n = 1; neg();
    chk("t5_busy", busy_o, 0); chk("t5_cnt", trap_cnt_o, 0); chk("t5_kill", wb_kill_o, 0);
    tick(); neg(); chk("t5_idle", busy_o, 0);
    clr();

`ifdef TRAP_MTVAL_EN
    tick(); wb_valid = 1; bus = 1; pc = 32'h8000_0004;
    tick(); clr(); repeat (3) tick(); tick(); neg();
    chk("t6_tval_a", csr_wr_addr_o, 12'h343); chk("t6_tval_d", csr_wr_data_o, 32'h8000_0004);
    tick(); tick(); wb_valid = 1; eb = 1;
    tick(); clr(); repeat (3) tick(); tick(); neg();
    chk("t6_ebk_tval", csr_wr_data_o, 0);
    tick(); tick();
`endif

    // randomized traffic, model checks every cycle
    for (int i = 0; i < 800; i++) begin
      tick();
      rst_n    = ($urandom_range(0, 199) != 0);
      wb_valid = $urandom_range(0, 1) != 0;
      mis = $urandom_range(0, 9) == 0; bus = $urandom_range(0, 9) == 0;
      il  = $urandom_range(0, 9) == 0; eb  = $urandom_range(0, 9) == 0;
      ec  = $urandom_range(0, 9) == 0; mr  = $urandom_range(0, 6) == 0;
      ready = $urandom_range(0, 3) != 0;
      pc = $urandom; mtvec = $urandom; mepc = $urandom;
    end
    tick(); clr(); rst_n = 1; ready = 1;
    repeat (12) tick();
    neg();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Writeback-stage trap sequencer. Samples the exception/mret flags registered into the MEM/WB pipeline register and picks the highest-priority trap. It kills the faulting writeback, flushes all stage registers, and writes mepc/mcause through a valid/ready CSR write port. It then redirects fetch to mtvec, or to mepc for mret. One instance sits beside mem_wb in the core top.

Parameters:
PC_W, 32, PC width (matches `PC_WIDTH)
XLEN_W, 32, data width (matches `XLEN)
FLUSH_CYCLES, 2, cycles flush_o is held high (1..15)
CNT_W, 32, width of trap_cnt_o

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
wb_valid_i  in  1  MEM/WB holds a valid instruction
wb_pc_i  in  PC_W  PC of WB instruction
wb_excp_misalign_i  in  1  fetch misaligned (cause 0)
wb_excp_bus_err_i  in  1  fetch bus error (cause 1)
wb_excp_ilegl_instr_i  in  1  illegal instruction (cause 2)
wb_excp_ebreak_i  in  1  ebreak (cause 3)
wb_excp_ecall_i  in  1  ecall from M (cause 11)
wb_excp_mret_i  in  1  mret retiring
mtvec_i  in  XLEN_W  current mtvec (direct mode)
mepc_i  in  XLEN_W  current mepc
csr_wr_valid_o  out  1  CSR write request
csr_wr_addr_o  out  12  CSR address (0x341 mepc, 0x342 mcause, 0x343 mtval)
csr_wr_data_o  out  XLEN_W  CSR write data
csr_wr_ready_i  in  1  CSR unit accepts write
wb_kill_o  out  1  suppress regfile writes this cycle (combinational)
flush_o  out  1  clear IF/ID, ID/EX, EX/MEM, MEM/WB
busy_o  out  1  FSM not IDLE; front end stalls
redirect_valid_o  out  1  one-cycle fetch redirect pulse
redirect_pc_o  out  PC_W  redirect target
trap_cnt_o  out  CNT_W  number of exceptions taken (mret not counted)

Behaviour:
- Clock port is clk. Reset port is rst_n: synchronous, active-low, sampled on posedge clk only.
- Reset values: all outputs 0, FSM IDLE, trap_cnt_o 0, internal cause/pc/target registers 0. Reset during any state returns to IDLE next edge; a pending CSR write is abandoned.
- Trap detect in IDLE: trap = wb_valid_i & any flag.
  - Priority: misalign > bus_err > ilegl_instr > ebreak > ecall > mret.
  - Any exception flag overrides a simultaneous mret.
- wb_kill_o = IDLE & trap (same cycle, combinational).
- Detection edge latches:
  - cause code; mret flag;
  - wb_pc_i;
  - target = mret ? mepc_i[PC_W-1:0] : {mtvec_i[PC_W-1:2],2'b00}.
- FSM:
  - IDLE -> FLUSH on trap. Load flush counter = FLUSH_CYCLES-1.
  - FLUSH: flush_o=1. Decrement the counter. At 0, go to REDIRECT if mret, else WR_EPC.
  - WR_EPC: csr_wr_valid_o=1, addr 0x341, data = zero-extended latched PC. Advance on valid&ready. Hold valid, addr and data stable while ready=0.
  - WR_CAUSE: addr 0x342, data = cause in bits [3:0], all other bits 0. Advance on valid&ready, to WR_TVAL if TRAP_MTVAL_EN, else REDIRECT.
  - REDIRECT: redirect_valid_o=1 for exactly one cycle, redirect_pc_o=target. Then IDLE.
- busy_o = state != IDLE. Flags arriving while busy are ignored, since the pipeline is flushed.
- trap_cnt_o increments on the IDLE->FLUSH edge for non-mret traps. Wraps modulo 2^CNT_W.
- Latency with ready=1: redirect pulse at detection cycle + FLUSH_CYCLES + 3 (exception), + FLUSH_CYCLES + 1 (mret).
- wb_valid_i=0 never triggers a trap, whatever the flags.

Optional Feature:
TRAP_MTVAL_EN
- Defined: adds state WR_TVAL after WR_CAUSE. Writes addr 0x343 with data = latched PC for causes 0/1, else 0. Exception redirect latency +1.
- Undefined: no WR_TVAL state, no 0x343 write.

Decomposition:
- Shared package/defines.v: cause codes (CAUSE_IMISALIGN=0, CAUSE_IACCESS=1, CAUSE_ILLEGAL=2, CAUSE_BREAK=3, CAUSE_ECALL_M=11), CSR addresses MEPC/MCAUSE/MTVAL, FSM state encodings.
- One natural sub-module: trap_prio_enc. Combinational priority encoder from flag vector to {trap, is_mret, cause[3:0]}.
- State and flop storage use the existing dff cell.

Test Plan:
- ilegl_instr, wb_pc=0x80000010, mtvec=0x80000101, ready=1, FLUSH_CYCLES=2 -> wb_kill same cycle; flush 2 cycles; writes 0x341=0x80000010 then 0x342=2; redirect_pc=0x80000100 at T+5; trap_cnt=1.
- misalign+ecall+mret together -> cause 0 chosen; redirect to mtvec, not mepc.
- mret alone, mepc=0x80000200 -> no CSR writes; redirect 0x80000200 at T+3; trap_cnt unchanged.
- ecall with ready low 4 cycles in WR_EPC -> valid/addr/data held stable; mcause=11 written after; redirect delayed 4 cycles.
- rst_n=0 during WR_CAUSE -> next cycle all outputs 0, IDLE, trap_cnt=0; flags with wb_valid=0 -> no response.
- TRAP_MTVAL_EN, bus_err at 0x80000004 -> third write 0x343=0x80000004; ebreak -> 0x343=0.
